ecc_secded_decoder: RTL and testbench

- Parametrised SECDED (extended Hamming) decoder for the on-chip ECC path. It is the next generation of the fixed 16-bit single-error-correcting decoder.
- Adds: generic data width, an overall-parity bit for double-error detection, a 2-stage pipeline with valid/ready backpressure, error flags, saturating error counters and an ECC bypass mode.
- Sits between a storage or link receiver and the consuming datapath.

---
 rtl/ecc_pkg.sv | 40 ++++
 rtl/ecc_syndrome_calc.sv | 26 ++
 rtl/ecc_secded_decoder.sv | 160 ++++++++++++++++
 tb/tb_ecc_secded_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED sizing helpers and word status encoding
// for the decoder pipeline and the syndrome calculator.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_CLEAN,
        ECC_CORR,
        ECC_PAR_CORR,
        ECC_UNCORR
    } ecc_status_e;

    function automatic int calc_parity_bits(input int data_width);
        int p;
        p = 1;
        while ((1 << p) < data_width + p + 1) begin
            p++;
        end
        return p;
    endfunction

    function automatic int code_width(input int data_width);
        return data_width + calc_parity_bits(data_width) + 1;
    endfunction

    // Power-of-two Hamming positions hold parity; data fills the rest.
    function automatic int data_position(input int index);
        int pos;
        int seen;
        pos  = 0;
        seen = -1;
        while (seen < index) begin
            pos++;
            if ((pos & (pos - 1)) != 0) begin
                seen++;
            end
        end
        return pos - 1;
    endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// ecc_syndrome_calc: combinational Hamming syndrome and overall parity
// of a SECDED code word; shared with the encoder self-check.
module ecc_syndrome_calc
    import ecc_pkg::*;
#(
    parameter int CODE_WIDTH  = 22,
    parameter int PARITY_BITS = 5
) (
    input  logic [CODE_WIDTH-1:0]  code_i,
    output logic [PARITY_BITS-1:0] syndrome_o,
    output logic                   parity_o
);

    // XOR of the positions of all set bits equals the per-bit syndrome.
    always_comb begin
        syndrome_o = '0;
        for (int i = 0; i < CODE_WIDTH - 1; i++) begin
            if (code_i[i]) begin
                syndrome_o = syndrome_o ^ PARITY_BITS'(i + 1);
            end
        end
    end

    assign parity_o = ^code_i;

endmodule

// File: rtl/ecc_secded_decoder.sv
// ecc_secded_decoder: 2-stage SECDED decoder with valid/ready flow,
// error flags, saturating error counters and a bypass mode.
module ecc_secded_decoder
    import ecc_pkg::*;
#(
    parameter int  DATA_WIDTH  = 16,
    parameter int  CNT_WIDTH   = 8,
    localparam int PARITY_BITS = calc_parity_bits(DATA_WIDTH),
    localparam int CODE_WIDTH  = code_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  ecc_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_WIDTH-1:0] in_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  err_corr,
    output logic                  err_uncorr,
    output logic [CNT_WIDTH-1:0]  corr_count,
    output logic [CNT_WIDTH-1:0]  uncorr_count,
    input  logic                  cnt_clr
);

    logic [PARITY_BITS-1:0] syn_d;
    logic                   par_d;
    logic [DATA_WIDTH-1:0]  raw_d;

    logic                   s1_valid_q;
    logic [DATA_WIDTH-1:0]  s1_data_q;
    logic [PARITY_BITS-1:0] s1_syn_q;
    logic                   s1_par_q;
    logic                   s1_en_q;

    logic                   s2_valid_q;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   corr_q, corr_d;
    logic                   uncorr_q, uncorr_d;
    logic [CNT_WIDTH-1:0]   corr_cnt_q, corr_cnt_d;
    logic [CNT_WIDTH-1:0]   uncorr_cnt_q, uncorr_cnt_d;

    ecc_status_e status;
    logic        in_fire;
    logic        s1_advance;
    logic        s2_load;
    logic        out_fire;

    ecc_syndrome_calc #(
        .CODE_WIDTH  (CODE_WIDTH),
        .PARITY_BITS (PARITY_BITS)
    ) u_syn (
        .code_i     (in_code),
        .syndrome_o (syn_d),
        .parity_o   (par_d)
    );

    assign out_fire   = s2_valid_q && out_ready;
    assign s2_load    = !s2_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_load;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign in_fire    = in_valid && in_ready;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_data
        localparam int POS = data_position(g);
        assign raw_d[g]  = in_code[POS];
        assign data_d[g] = s1_data_q[g]
                         ^ ((status == ECC_CORR)
                         && (s1_syn_q == PARITY_BITS'(POS + 1)));
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s1_en_q    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_fire) begin
                s1_data_q <= raw_d;
                s1_syn_q  <= syn_d;
                s1_par_q  <= par_d;
                s1_en_q   <= ecc_en;
            end
        end
    end

    // A syndrome beyond the last position is treated as uncorrectable.
    always_comb begin
        status = ECC_CLEAN;
        if (s1_en_q) begin
            unique case (1'b1)
                (s1_syn_q == '0 && !s1_par_q): status = ECC_CLEAN;
                (s1_syn_q == '0 && s1_par_q):  status = ECC_PAR_CORR;
                (s1_syn_q != '0 && s1_par_q
                 && s1_syn_q <= PARITY_BITS'(CODE_WIDTH - 1)):
                    status = ECC_CORR;
                default: status = ECC_UNCORR;
            endcase
        end
    end

    assign corr_d   = (status == ECC_CORR) || (status == ECC_PAR_CORR);
    assign uncorr_d = (status == ECC_UNCORR);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            corr_q     <= 1'b0;
            uncorr_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q   <= data_d;
                corr_q   <= corr_d;
                uncorr_q <= uncorr_d;
            end
        end
    end

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_fire) begin
            if (corr_q && corr_cnt_q != '1) begin
                corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
            end
            if (uncorr_q && uncorr_cnt_q != '1) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = data_q;
    assign err_corr     = corr_q;
    assign err_uncorr   = uncorr_q;
    assign corr_count   = corr_cnt_q;
    assign uncorr_count = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// tb_ecc_secded_decoder: directed table, corner sequences and random
// traffic against a nearest-codeword reference decoder.
module tb_ecc_secded_decoder;

    localparam int DW   = 16;
    localparam int CW   = 22;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic            clk = 1'b0;
    logic            rstb = 1'b0;
    logic            ecc_en = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW-1:0]   in_code = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic            err_corr;
    logic            err_uncorr;
    logic [CNTW-1:0] corr_count;
    logic [CNTW-1:0] uncorr_count;
    logic            cnt_clr = 1'b0;

    always #5 clk = ~clk;

    ecc_secded_decoder #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CNTW)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .ecc_en       (ecc_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .err_corr     (err_corr),
        .err_uncorr   (err_uncorr),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count),
        .cnt_clr      (cnt_clr)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          corr;
        logic          uncorr;
    } exp_t;

    typedef struct {
        logic [CW-1:0] code;
        logic          en;
        exp_t          e;
    } vec_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   checks = 0;
    int   failures = 0;
    int   cc_m = 0;
    int   uc_m = 0;
    bit   accepted = 1'b0;
    bit   rnd_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
        logic [DW-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = c[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int k;
        c = '0;
        k = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 0; (1 << p) < CW; p++) begin
            logic x;
            x = 1'b0;
            for (int pos = 1; pos < CW; pos++) begin
                if (((pos >> p) & 1) != 0 && (pos & (pos - 1)) != 0)
                    x ^= c[pos-1];
            end
            c[(1 << p) - 1] = x;
        end
        c[CW-1] = ^c[CW-2:0];
        return c;
    endfunction

    // Decode by searching for the nearest valid code word.
    function automatic exp_t ref_decode(input logic [CW-1:0] c,
                                        input logic en);
        exp_t e;
        logic [CW-1:0] t;
        e.data   = extract(c);
        e.corr   = 1'b0;
        e.uncorr = 1'b0;
        if (!en) return e;
        if (encode(extract(c)) == c) return e;
        for (int i = 0; i < CW; i++) begin
            t = c;
            t[i] = ~t[i];
            if (encode(extract(t)) == t) begin
                e.data = extract(t);
                e.corr = 1'b1;
                return e;
            end
        end
        e.uncorr = 1'b1;
        return e;
    endfunction

    task automatic tick();
        bit   inf;
        bit   outf;
        bit   clr;
        exp_t e;
        @(negedge clk);
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        clr  = cnt_clr;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out: out_valid=1 expected 0");
            end else begin
                chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                chk("err_corr", 64'(err_corr), 64'(exp_q[0].corr));
                chk("err_uncorr", 64'(err_uncorr), 64'(exp_q[0].uncorr));
            end
        end
        chk("corr_count", 64'(corr_count), 64'(cc_m));
        chk("uncorr_count", 64'(uncorr_count), 64'(uc_m));
        @(posedge clk);
        if (outf && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.corr && cc_m < CMAX) cc_m++;
            if (e.uncorr && uc_m < CMAX) uc_m++;
        end
        if (clr) begin
            cc_m = 0;
            uc_m = 0;
        end
        if (inf) exp_q.push_back(cur_exp);
        accepted = inf;
        #1;
        if (rnd_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 40) == 0);
        end
    endtask

    task automatic send(input logic [CW-1:0] code, input logic en,
                        input exp_t e);
        int n;
        n        = 0;
        in_code  = code;
        ecc_en   = en;
        cur_exp  = e;
        in_valid = 1'b1;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            tick();
            n++;
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    vec_t          tbl[9];
    logic [CW-1:0] c;
    logic [CW-1:0] wa, wb, wc;
    logic          en;
    int            ne;

    initial begin
        tbl[0] = '{22'h000000, 1'b1, '{16'h0000, 1'b0, 1'b0}};
        tbl[1] = '{22'h1FFFFE, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
        tbl[2] = '{22'h000200, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        tbl[3] = '{22'h200000, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        tbl[4] = '{22'h000024, 1'b1, '{16'h0005, 1'b0, 1'b1}};
        tbl[5] = '{22'h0080C0, 1'b1, '{16'h0008, 1'b0, 1'b1}};
        tbl[6] = '{22'h3FFFFE, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
        tbl[7] = '{22'h1FFFFA, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
        tbl[8] = '{22'h000024, 1'b0, '{16'h0005, 1'b0, 1'b0}};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_flags", 64'({err_corr, err_uncorr}), 64'(0));
        chk("rst_counts", 64'({corr_count, uncorr_count}), 64'(0));
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        foreach (tbl[i]) begin
            send(tbl[i].code, tbl[i].en, tbl[i].e);
            chk("lat1_valid", 64'(out_valid), 64'(0));
            tick();
            chk("lat2_valid", 64'(out_valid), 64'(1));
            drain();
        end

        // Two words fill the pipe under backpressure; the third waits.
        wa = encode(16'h1234);
        wb = encode(16'hBEEF) ^ 22'h000010;
        wc = 22'h000024;
        out_ready = 1'b0;
        send(wa, 1'b1, ref_decode(wa, 1'b1));
        send(wb, 1'b1, ref_decode(wb, 1'b1));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        in_code  = wc;
        in_valid = 1'b1;
        cur_exp  = ref_decode(wc, 1'b1);
        repeat (5) begin
            tick();
            chk("bp_no_accept", 64'(accepted), 64'(0));
            chk("bp_stall_ready", 64'(in_ready), 64'(0));
            chk("bp_stall_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        send(wc, 1'b1, ref_decode(wc, 1'b1));
        drain();

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        repeat (20) begin
            c = encode(16'($urandom));
            c[$urandom_range(0, CW - 1)] ^= 1'b1;
            send(c, 1'b1, ref_decode(c, 1'b1));
        end
        drain();
        chk("corr_sat", 64'(corr_count), 64'(15));

        c = encode(16'h00FF) ^ 22'h000400;
        send(c, 1'b1, ref_decode(c, 1'b1));
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_priority", 64'(corr_count), 64'(0));
        drain();

        send(22'h000200, 1'b0, '{16'h0020, 1'b0, 1'b0});
        drain();
        chk("bypass_corr_cnt", 64'(corr_count), 64'(0));
        chk("bypass_uncorr_cnt", 64'(uncorr_count), 64'(0));

        rnd_mode = 1'b1;
        repeat (300) begin
            c  = encode(16'($urandom));
            ne = int'($urandom_range(0, 3));
            for (int j = 0; j < ne; j++) c[$urandom_range(0, CW - 1)] ^= 1'b1;
            en = ($urandom_range(0, 9) != 0);
            repeat ($urandom_range(0, 2)) tick();
            send(c, en, ref_decode(c, en));
        end
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        drain();

        c = 22'h000200;
        send(c, 1'b1, ref_decode(c, 1'b1));
        drain();
        chk("pre_rst_count", 64'(corr_count != '0), 64'(1));
        out_ready = 1'b0;
        send(wa, 1'b1, ref_decode(wa, 1'b1));
        send(wb, 1'b1, ref_decode(wb, 1'b1));
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_data", 64'(out_data), 64'(0));
        chk("mid_rst_flags", 64'({err_corr, err_uncorr}), 64'(0));
        chk("mid_rst_counts", 64'({corr_count, uncorr_count}), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        cc_m = 0;
        uc_m = 0;
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send(22'h1FFFFE, 1'b1, '{16'hFFFF, 1'b0, 1'b0});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
